frameblock_scheduler: RTL and testbench
=======================================

FRAMEBLOCK_SCHEDULER -- requirements
Module: frameblock_scheduler

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port frame_start  in  1  one-cycle pulse: begin a 128-block frame.
REQ-004 SHALL have port frame_abort  in  1  one-cycle pulse: abandon the current frame.
REQ-005 SHALL have port render_start  out  1  one-cycle pulse: renderer may fill render_buf with block render_id.
REQ-006 SHALL have port render_id  out  7  block id for the renderer, {row[2:0], col[3:0]}.
REQ-007 SHALL have port render_buf  out  1  tile buffer index for the renderer.
REQ-008 SHALL have port render_done  in  1  one-cycle pulse: renderer finished its current buffer.
REQ-009 SHALL have port frameblock_id  out  7  block id presented to the LCD controller.
REQ-010 SHALL have port frameblock_buf  out  1  tile buffer index the LCD controller reads.
REQ-011 SHALL have port frameblock_ready  out  1  level: presented block is complete and readable.
REQ-012 SHALL have port frameblock_next  in  1  one-cycle pulse: LCD controller consumed the presented block.
REQ-013 SHALL have port frame_busy  out  1  level: frame in progress.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse: all 128 blocks consumed.

Function
REQ-015 SHALL hold 2 tile buffers, each in state EMPTY, RENDERING, FULL or SENDING; at most one RENDERING and at most one SENDING at a time.
REQ-016 SHALL keep an 8-bit render count rc (0..128) and an 8-bit send count sc (0..128); render_id = rc[6:0], frameblock_id = sc[6:0].
REQ-017 SHALL keep a render pointer rp and a send pointer sp, each 1 bit; each toggles only on completion of its own buffer.
REQ-018 When idle, frame_start SHALL set busy=1, rc=sc=0, rp=sp=0 and both buffers EMPTY; frame_start while busy SHALL be ignored.
REQ-019 Dispatch SHALL occur when busy, no buffer RENDERING, rc<128 and buffer[rp] EMPTY: buffer[rp] goes to RENDERING, render_start pulses for 1 cycle, render_id=rc and render_buf=rp.
REQ-020 render_done while a buffer is RENDERING SHALL set it FULL, increment rc and toggle rp; render_done otherwise SHALL be ignored.
REQ-021 Present SHALL occur when busy, no buffer SENDING and buffer[sp] FULL: buffer[sp] goes to SENDING, frameblock_ready=1, frameblock_id=sc and frameblock_buf=sp.
REQ-022 frameblock_next while a buffer is SENDING SHALL set it EMPTY, drop frameblock_ready the next cycle, increment sc and toggle sp.
REQ-023 frameblock_next with no SENDING buffer SHALL be ignored, including the spurious pulse the LCD controller emits after its own reset.
REQ-024 All outputs SHALL be registered; all decisions use registered state, so a buffer freed or filled in cycle N is dispatched or presented no earlier than cycle N+1.
REQ-025 Latency SHALL be exactly 1 cycle for each of: EMPTY-to-render_start, FULL-to-frameblock_ready, frame_start-to-first render_start.
REQ-026 render_done and frameblock_next in the same cycle SHALL both take effect.
REQ-027 When sc increments from 127 to 128, the scheduler SHALL pulse frame_done for 1 cycle in the following cycle and clear busy in that same cycle.
REQ-028 frame_abort SHALL, next cycle, clear busy, frameblock_ready and render_start, and set both buffers EMPTY with no frame_done pulse; a later render_done/frameblock_next SHALL be ignored.
REQ-029 frame_abort and frame_start in the same cycle: abort SHALL win; frame_start is dropped.
REQ-030 render_id/frameblock_id/buf outputs SHALL hold their last value while their strobe or level is inactive.

Reset
REQ-031 On rst_n=0 at a clock edge, the scheduler SHALL set: all outputs 0, rc=sc=0, rp=sp=0, both buffers EMPTY, idle; reset SHALL override every other input, including mid-frame.

Verification
REQ-032 Reset then frame_start at cycle 0 -> render_start=1, render_id=0, render_buf=0 at cycle 1; frameblock_ready=0.
REQ-033 Fast renderer (render_done 3 cycles after each start), LCD next 10 cycles after ready -> ids 0..127 presented in order, buffers alternate 0/1, frame_done once, busy falls with it.
REQ-034 frameblock_next pulsed right after reset and again during idle -> no state change, sc stays 0, frameblock_ready stays 0.
REQ-035 Block 5 FULL in buf1 and block 4 SENDING in buf0; render_done and frameblock_next in the same cycle -> next cycle buf0 EMPTY, ready=0; following cycle ready=1 id=5 buf=1 and render_start id=6 buf=0.
REQ-036 frame_abort at sc=40 with a buffer RENDERING -> busy=0, ready=0, no frame_done; later render_done ignored; new frame_start restarts at id 0 buf 0.
REQ-037 rst_n=0 asserted mid-frame for 1 cycle -> all outputs 0 next cycle; frame_start then behaves as after power-on.

Source files
------------

// File: rtl/frameblock_scheduler.sv
// frameblock_scheduler: double-buffered block scheduler between a tile renderer and an LCD controller
module frameblock_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       frame_abort,
  output logic       render_start,
  output logic [6:0] render_id,
  output logic       render_buf,
  input  logic       render_done,
  output logic [6:0] frameblock_id,
  output logic       frameblock_buf,
  output logic       frameblock_ready,
  input  logic       frameblock_next,
  output logic       frame_busy,
  output logic       frame_done
);
  localparam logic [1:0] EMPTY = 2'd0, RENDERING = 2'd1, FULL = 2'd2, SENDING = 2'd3;
  logic [1:0] bs [2];
  logic [1:0] bs_n [2];
  logic [7:0] rc, sc, rc_n, sc_n;
  logic rp, sp, rp_n, sp_n;
  logic rendering, sending, live, start, rdone, snext, dispatch, present, done_n, busy_n, ready_n;
  always_comb begin
    rendering = bs[0] == RENDERING || bs[1] == RENDERING;
    sending = bs[0] == SENDING || bs[1] == SENDING;
    live = frame_busy && !frame_abort;
    start = frame_start && !frame_busy && !frame_abort;
    rdone = live && render_done && rendering;
    snext = live && frameblock_next && sending;
    rc_n = start ? 8'd0 : rc + {7'd0, rdone};
    sc_n = start ? 8'd0 : sc + {7'd0, snext};
    rp_n = !start && (rp ^ rdone);
    sp_n = !start && (sp ^ snext);
    dispatch = start || (live && !rendering && !rc[7] && bs[rp] == EMPTY);
    present = live && !sending && bs[sp] == FULL;
    done_n = snext && sc == 8'd127;
    busy_n = start || (live && !done_n);
    for (int i = 0; i < 2; i++)
      bs_n[i] = (dispatch && rp_n == 1'(i)) ? RENDERING :
                !live ? EMPTY :
                (present && sp == 1'(i)) ? SENDING :
                (rdone && bs[i] == RENDERING) ? FULL :
                (snext && bs[i] == SENDING) ? EMPTY : bs[i];
    ready_n = bs_n[0] == SENDING || bs_n[1] == SENDING;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bs <= '{EMPTY, EMPTY};
      rc <= 8'd0;
      sc <= 8'd0;
      rp <= 1'b0;
      sp <= 1'b0;
      render_start <= 1'b0;
      render_id <= 7'd0;
      render_buf <= 1'b0;
      frameblock_id <= 7'd0;
      frameblock_buf <= 1'b0;
      frameblock_ready <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bs <= bs_n;
      rc <= rc_n;
      sc <= sc_n;
      rp <= rp_n;
      sp <= sp_n;
      render_start <= dispatch;
      render_id <= dispatch ? rc_n[6:0] : render_id;
      render_buf <= dispatch ? rp_n : render_buf;
      frameblock_id <= present ? sc[6:0] : frameblock_id;
      frameblock_buf <= present ? sp : frameblock_buf;
      frameblock_ready <= ready_n;
      frame_busy <= busy_n;
      frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_frameblock_scheduler.sv
// tb_frameblock_scheduler: vector table, scenario and randomized checks against a count-based model
module tb_frameblock_scheduler;
  logic clk = 0, rst_n = 0, frame_start = 0, frame_abort = 0, render_done = 0, frameblock_next = 0;
  logic render_start, render_buf, frameblock_buf, frameblock_ready, frame_busy, frame_done;
  logic [6:0] render_id, frameblock_id;
  int total = 0, bad = 0;
  int rwait = 0, nwait = 0, rlat = 1, nlat = 1, hold = -1, npres = 0, ndone = 0;
  bit prev_rdy = 0, track = 0;
  bit mbusy = 0, mrend = 0, msend = 0, mrs = 0, mrbuf = 0, mrdy = 0, mfbuf = 0, mdone = 0;
  int mrc = 0, msc = 0;
  logic [6:0] mrid = 0, mfid = 0;
  typedef struct {
    logic r, fs, fa, rd, nx;
    logic [19:0] exp;
  } vec_t;
  vec_t tv [17];
  always #5 clk = ~clk;
  frameblock_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
    .render_start(render_start), .render_id(render_id), .render_buf(render_buf),
    .render_done(render_done), .frameblock_id(frameblock_id), .frameblock_buf(frameblock_buf),
    .frameblock_ready(frameblock_ready), .frameblock_next(frameblock_next),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );
  function automatic logic [19:0] pk(int rs, int rid, int rb, int rdy, int fid, int fb, int bz, int dn);
    return {1'(rs), 7'(rid), 1'(rb), 1'(rdy), 7'(fid), 1'(fb), 1'(bz), 1'(dn)};
  endfunction
  function automatic logic [19:0] dvec();
    return {render_start, render_id, render_buf, frameblock_ready, frameblock_id, frameblock_buf, frame_busy, frame_done};
  endfunction
  function automatic logic [19:0] mvec();
    return {mrs, mrid, mrbuf, mrdy, mfid, mfbuf, mbusy, mdone};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model(input logic r, input logic fs, input logic fa, input logic rd, input logic nx);
    int rc0, sc0;
    bit rend0, send0, busy0;
    rc0 = mrc; sc0 = msc; rend0 = mrend; send0 = msend; busy0 = mbusy;
    mrs = 0; mdone = 0;
    if (!r) begin
      mbusy = 0; mrc = 0; msc = 0; mrend = 0; msend = 0; mrid = 0; mrbuf = 0; mfid = 0; mfbuf = 0;
    end else if (fa) begin
      mbusy = 0; mrend = 0; msend = 0;
    end else if (fs && !busy0) begin
      mbusy = 1; mrc = 0; msc = 0; mrend = 1; msend = 0; mrs = 1; mrid = 0; mrbuf = 0;
    end else if (busy0) begin
      if (rd && rend0) begin mrend = 0; mrc++; end
      if (nx && send0) begin
        msend = 0; msc++;
        if (msc == 128) begin mdone = 1; mbusy = 0; end
      end
      if (!rend0 && rc0 < 128 && rc0 - sc0 < 2) begin
        mrend = 1; mrs = 1; mrid = 7'(rc0); mrbuf = 1'(rc0 % 2);
      end
      if (!send0 && sc0 < rc0) begin
        msend = 1; mfid = 7'(sc0); mfbuf = 1'(sc0 % 2);
      end
    end
    mrdy = msend;
  endtask
  task automatic step(input logic r, input logic fs, input logic fa, input logic rd, input logic nx);
    rst_n = r; frame_start = fs; frame_abort = fa; render_done = rd; frameblock_next = nx;
    @(posedge clk);
    model(r, fs, fa, rd, nx);
    #1;
    chk("model", 32'(dvec()), 32'(mvec()));
    if (render_start) rwait = rlat;
    if (frameblock_ready && !prev_rdy) begin
      if (track) begin
        chk("present id", 32'(frameblock_id), 32'(npres % 128));
        chk("present buf", 32'(frameblock_buf), 32'(npres % 2));
      end
      npres++;
      if (int'(frameblock_id) != hold) nwait = nlat;
    end
    prev_rdy = frameblock_ready;
    if (frame_done) begin
      ndone++;
      chk("busy with done", 32'(frame_busy), 0);
    end
  endtask
  task automatic agent_step();
    logic rd, nx;
    rd = rwait == 1;
    nx = nwait == 1;
    if (rwait > 0) rwait--;
    if (nwait > 0) nwait--;
    step(1, 0, 0, rd, nx);
  endtask
  task automatic setup(input int rl, input int nl, input int hd);
    rlat = rl; nlat = nl; hold = hd; rwait = 0; nwait = 0; npres = 0; ndone = 0; prev_rdy = 0;
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int nd;
    tv[0]  = '{0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tv[1]  = '{1, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tv[2]  = '{1, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tv[3]  = '{1, 1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 0)};
    tv[4]  = '{1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0)};
    tv[5]  = '{1, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0)};
    tv[6]  = '{1, 0, 0, 0, 0, pk(1, 1, 1, 1, 0, 0, 1, 0)};
    tv[7]  = '{1, 1, 0, 0, 0, pk(0, 1, 1, 1, 0, 0, 1, 0)};
    tv[8]  = '{1, 0, 0, 1, 1, pk(0, 1, 1, 0, 0, 0, 1, 0)};
    tv[9]  = '{1, 0, 0, 0, 0, pk(1, 2, 0, 1, 1, 1, 1, 0)};
    tv[10] = '{1, 0, 0, 0, 1, pk(0, 2, 0, 0, 1, 1, 1, 0)};
    tv[11] = '{1, 0, 0, 0, 1, pk(0, 2, 0, 0, 1, 1, 1, 0)};
    tv[12] = '{1, 1, 1, 0, 0, pk(0, 2, 0, 0, 1, 1, 0, 0)};
    tv[13] = '{1, 0, 0, 1, 0, pk(0, 2, 0, 0, 1, 1, 0, 0)};
    tv[14] = '{1, 1, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 1, 0)};
    tv[15] = '{0, 0, 0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0)};
    tv[16] = '{1, 1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1, 0)};
    for (int i = 0; i < 17; i++) begin
      step(tv[i].r, tv[i].fs, tv[i].fa, tv[i].rd, tv[i].nx);
      chk($sformatf("vec%0d", i), 32'(dvec()), 32'(tv[i].exp));
    end
    // full frame: render_done 3 cycles after each start, next 10 cycles after ready
    setup(4, 11, -1);
    track = 1;
    n = 0;
    while (ndone == 0 && n < 5000) begin agent_step(); n++; end
    for (int i = 0; i < 5; i++) agent_step();
    track = 0;
    chk("frame blocks", 32'(npres), 128);
    chk("frame done count", 32'(ndone), 1);
    chk("idle after frame", 32'(frame_busy), 0);
    // block 5 FULL in buf1, block 4 SENDING in buf0, simultaneous done and next
    setup(1, 2, 4);
    for (int i = 0; i < 60; i++) agent_step();
    chk("hold state", 32'(dvec()), 32'(pk(0, 5, 1, 1, 4, 0, 1, 0)));
    step(1, 0, 0, 1, 1);
    chk("same-cycle free", 32'(dvec()), 32'(pk(0, 5, 1, 0, 4, 0, 1, 0)));
    step(1, 0, 0, 0, 0);
    chk("same-cycle next", 32'(dvec()), 32'(pk(1, 6, 0, 1, 5, 1, 1, 0)));
    // abort at sc=40 while rendering
    setup(4, 3, -1);
    n = 0;
    while (!(msc == 40 && mrend) && n < 3000) begin agent_step(); n++; end
    chk("reach sc40", 32'(msc == 40 && mrend), 1);
    nd = ndone;
    step(1, 0, 1, 0, 0);
    chk("abort outputs", 32'({render_start, frameblock_ready, frame_busy, frame_done}), 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("abort stays idle", 32'({render_start, frameblock_ready, frame_busy}), 0);
    chk("abort no done", 32'(ndone), 32'(nd));
    step(1, 1, 0, 0, 0);
    chk("restart", 32'({render_start, render_id, render_buf, frame_busy}), 32'({1'b1, 7'd0, 1'b0, 1'b1}));
    // reset mid-frame
    setup(2, 2, -1);
    for (int i = 0; i < 50; i++) agent_step();
    step(0, 0, 0, 1, 1);
    chk("mid reset", 32'(dvec()), 0);
    step(1, 1, 0, 0, 0);
    chk("start after reset", 32'(dvec()), 32'(pk(1, 0, 0, 0, 0, 0, 1, 0)));
    // randomized traffic against the model
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 2999) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1499) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
